// File: rtl/watch_edit_ctrl.sv
// Edit-mode controller: cursor over NUM_DIGITS fields, step pulses, blink phase and exit reporting.
// Optional inactivity exit is built when WATCH_EDIT_TIMEOUT_EN is defined.
module watch_edit_ctrl #(
    parameter int NUM_DIGITS    = 4,
    parameter int TIMEOUT_TICKS = 10,
    parameter int BLINK_TICKS   = 1,
    localparam int CW           = $clog2(NUM_DIGITS + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_btn_center,
    input  logic          i_btn_left,
    input  logic          i_btn_right,
    input  logic          i_btn_up,
    input  logic          i_btn_down,
    input  logic          i_tick,
    output logic [CW-1:0] o_cursor,
    output logic          o_blink_en,
    output logic          o_blink_on,
    output logic          o_inc,
    output logic          o_dec,
    output logic [CW-1:0] o_sel,
    output logic          o_commit,
    output logic          o_timeout
);
    localparam int PW = $clog2(BLINK_TICKS + 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 15 || BLINK_TICKS < 1 || TIMEOUT_TICKS < 1) begin : g_bad_params
        $error("watch_edit_ctrl: parameter out of range");
    end

    typedef enum logic {IDLE, EDIT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cursor_n, sel_n;
    logic [PW-1:0] phase, phase_n;
    logic          blink_n, inc_n, dec_n, commit_n, timeout_n;
    logic          any_btn;

    assign any_btn    = i_btn_center | i_btn_right | i_btn_left | i_btn_up | i_btn_down;
    assign o_blink_en = (o_cursor != '0);

`ifdef WATCH_EDIT_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_TICKS + 1);
    logic [IW-1:0] idle_cnt, idle_n;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            o_cursor   <= '0;
            o_blink_on <= 1'b1;
            phase      <= '0;
            o_inc      <= 1'b0;
            o_dec      <= 1'b0;
            o_sel      <= '0;
            o_commit   <= 1'b0;
        end else begin
            state      <= state_n;
            o_cursor   <= cursor_n;
            o_blink_on <= blink_n;
            phase      <= phase_n;
            o_inc      <= inc_n;
            o_dec      <= dec_n;
            o_sel      <= sel_n;
            o_commit   <= commit_n;
        end
    end

`ifdef WATCH_EDIT_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt  <= '0;
            o_timeout <= 1'b0;
        end else begin
            idle_cnt  <= idle_n;
            o_timeout <= timeout_n;
        end
    end
`else
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        cursor_n  = o_cursor;
        blink_n   = o_blink_on;
        phase_n   = phase;
        inc_n     = 1'b0;
        dec_n     = 1'b0;
        sel_n     = '0;
        commit_n  = 1'b0;
        timeout_n = 1'b0;
`ifdef WATCH_EDIT_TIMEOUT_EN
        idle_n    = idle_cnt;
`endif
        case (state)
            IDLE: begin
                blink_n = 1'b1;
                phase_n = '0;
`ifdef WATCH_EDIT_TIMEOUT_EN
                idle_n  = '0;
`endif
                if (i_btn_center) begin
                    state_n  = EDIT;
                    cursor_n = CW'(1);
                end
            end
            EDIT: begin
                // A button always restarts both time bases; any coincident tick is dropped.
                if (any_btn) begin
                    blink_n = 1'b1;
                    phase_n = '0;
`ifdef WATCH_EDIT_TIMEOUT_EN
                    idle_n  = '0;
`endif
                end
                if (i_btn_center) begin
                    state_n  = IDLE;
                    cursor_n = '0;
                    commit_n = 1'b1;
                end else if (i_btn_right) begin
                    cursor_n = (o_cursor == CW'(NUM_DIGITS)) ? CW'(1) : o_cursor + CW'(1);
                end else if (i_btn_left) begin
                    cursor_n = (o_cursor == CW'(1)) ? CW'(NUM_DIGITS) : o_cursor - CW'(1);
                end else if (i_btn_up) begin
                    inc_n = 1'b1;
                    sel_n = o_cursor;
                end else if (i_btn_down) begin
                    dec_n = 1'b1;
                    sel_n = o_cursor;
                end else if (i_tick) begin
                    if (phase == PW'(BLINK_TICKS - 1)) begin
                        phase_n = '0;
                        blink_n = ~o_blink_on;
                    end else begin
                        phase_n = phase + PW'(1);
                    end
`ifdef WATCH_EDIT_TIMEOUT_EN
                    if (idle_cnt == IW'(TIMEOUT_TICKS - 1)) begin
                        state_n   = IDLE;
                        cursor_n  = '0;
                        timeout_n = 1'b1;
                        blink_n   = 1'b1;
                        phase_n   = '0;
                        idle_n    = '0;
                    end else begin
                        idle_n = idle_cnt + IW'(1);
                    end
`endif
                end
            end
            default: begin
                state_n  = IDLE;
                cursor_n = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_watch_edit_ctrl.sv
// Directed bench for watch_edit_ctrl with NUM_DIGITS=4, TIMEOUT_TICKS=3, BLINK_TICKS=2.
module tb_watch_edit_ctrl;
    localparam int CW = 3;

    logic clk = 1'b0, reset_n = 1'b0;
    logic c = 0, l = 0, r = 0, u = 0, d = 0, t = 0;
    logic [CW-1:0] cursor, sel;
    logic blink_en, blink_on, inc, dec, commit, timeout;
    int errors = 0, checks = 0;

    watch_edit_ctrl #(.NUM_DIGITS(4), .TIMEOUT_TICKS(3), .BLINK_TICKS(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_btn_center(c), .i_btn_left(l), .i_btn_right(r), .i_btn_up(u), .i_btn_down(d),
        .i_tick(t),
        .o_cursor(cursor), .o_blink_en(blink_en), .o_blink_on(blink_on),
        .o_inc(inc), .o_dec(dec), .o_sel(sel), .o_commit(commit), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs from a negedge; returns at the next negedge with outputs settled.
    task automatic drive(input logic bc, br, bl, bu, bd, bt);
        c = bc; r = br; l = bl; u = bu; d = bd; t = bt;
        @(negedge clk);
        c = 0; r = 0; l = 0; u = 0; d = 0; t = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cursor !== 3'd0) begin errors++; $display("FAIL reset_cursor got=%0d exp=0", cursor); end
        checks++; if (blink_en !== 1'b0) begin errors++; $display("FAIL reset_blink_en got=%0b exp=0", blink_en); end
        checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL reset_blink_on got=%0b exp=1", blink_on); end
        checks++; if ({inc, dec, commit, timeout, sel} !== 7'd0) begin errors++; $display("FAIL reset_pulses got=%b exp=0", {inc, dec, commit, timeout, sel}); end
        reset_n = 1'b1;
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0);
        checks++; if (cursor !== 3'd0) begin errors++; $display("FAIL idle_up_cursor got=%0d exp=0", cursor); end
        checks++; if (inc !== 1'b0 || blink_on !== 1'b1) begin errors++; $display("FAIL idle_up_pulse inc=%0b blink_on=%0b exp inc=0 blink_on=1", inc, blink_on); end
    endtask

    task automatic test_cursor();
        logic [CW-1:0] exp_seq [5] = '{3'd2, 3'd3, 3'd4, 3'd1, 3'd4};
        drive(1, 0, 0, 0, 0, 0);
        checks++; if (cursor !== 3'd1 || blink_en !== 1'b1) begin errors++; $display("FAIL enter_cursor got=%0d en=%0b exp=1 en=1", cursor, blink_en); end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(0, 1, 0, 0, 0, 0);
            else       drive(0, 0, 1, 0, 0, 0);
            checks++; if (cursor !== exp_seq[i]) begin errors++; $display("FAIL move_%0d cursor got=%0d exp=%0d", i, cursor, exp_seq[i]); end
        end
        drive(1, 0, 0, 0, 0, 0);
        checks++; if (cursor !== 3'd0 || commit !== 1'b1) begin errors++; $display("FAIL exit_commit cursor=%0d commit=%0b exp 0/1", cursor, commit); end
        @(negedge clk);
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL commit_width got=%0b exp=0", commit); end
    endtask

    task automatic test_step();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        checks++; if ({inc, dec, sel, cursor} !== {1'b1, 1'b0, 3'd3, 3'd3}) begin errors++; $display("FAIL step_up inc=%0b dec=%0b sel=%0d cursor=%0d exp 1/0/3/3", inc, dec, sel, cursor); end
        drive(0, 0, 0, 0, 1, 0);
        checks++; if ({inc, dec, sel, cursor} !== {1'b0, 1'b1, 3'd3, 3'd3}) begin errors++; $display("FAIL step_down inc=%0b dec=%0b sel=%0d cursor=%0d exp 0/1/3/3", inc, dec, sel, cursor); end
        @(negedge clk);
        checks++; if ({inc, dec, sel} !== 5'd0) begin errors++; $display("FAIL step_clear got=%b exp=0", {inc, dec, sel}); end
        drive(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_priority();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0);
        checks++; if (cursor !== 3'd2 || inc !== 1'b0) begin errors++; $display("FAIL prio_lru cursor=%0d inc=%0b exp 2/0", cursor, inc); end
        drive(1, 1, 0, 0, 0, 0);
        checks++; if (cursor !== 3'd0 || commit !== 1'b1) begin errors++; $display("FAIL prio_cr cursor=%0d commit=%0b exp 0/1", cursor, commit); end
    endtask

    task automatic test_blink_timeout();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL blink_t1 got=%0b exp=1", blink_on); end
        drive(0, 0, 0, 0, 0, 1);
        checks++; if (blink_on !== 1'b0) begin errors++; $display("FAIL blink_t2 got=%0b exp=0", blink_on); end
`ifdef WATCH_EDIT_TIMEOUT_EN
        drive(0, 0, 0, 0, 0, 1);
        checks++; if ({cursor, timeout, commit, blink_on} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin errors++; $display("FAIL timeout_t3 cursor=%0d to=%0b cm=%0b bo=%0b exp 0/1/0/1", cursor, timeout, commit, blink_on); end
        @(negedge clk);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_width got=%0b exp=0", timeout); end
        // Button on the 2nd tick restarts the inactivity count.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 1);
        checks++; if (inc !== 1'b1 || blink_on !== 1'b1) begin errors++; $display("FAIL tick_btn inc=%0b bo=%0b exp 1/1", inc, blink_on); end
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        checks++; if (cursor !== 3'd1 || timeout !== 1'b0 || blink_on !== 1'b0) begin errors++; $display("FAIL restart_t2 cursor=%0d to=%0b bo=%0b exp 1/0/0", cursor, timeout, blink_on); end
        drive(0, 0, 0, 0, 0, 1);
        checks++; if (cursor !== 3'd0 || timeout !== 1'b1) begin errors++; $display("FAIL restart_t3 cursor=%0d to=%0b exp 0/1", cursor, timeout); end
        // Centre coinciding with the timeout tick commits instead.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1);
        checks++; if ({cursor, commit, timeout} !== {3'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL centre_vs_timeout cursor=%0d cm=%0b to=%0b exp 0/1/0", cursor, commit, timeout); end
`else
        for (int i = 3; i <= 10; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            checks++; if (blink_on !== (((i / 2) % 2) == 0) || timeout !== 1'b0) begin errors++; $display("FAIL blink_t%0d bo=%0b to=%0b exp bo=%0b to=0", i, blink_on, timeout, (((i / 2) % 2) == 0)); end
        end
        checks++; if (cursor !== 3'd1) begin errors++; $display("FAIL no_timeout cursor=%0d exp=1", cursor); end
        drive(1, 0, 0, 0, 0, 0);
`endif
    endtask

    task automatic test_reset_mid_edit();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        u = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (inc !== 1'b1 || sel !== 3'd2) begin errors++; $display("FAIL pending_inc inc=%0b sel=%0d exp 1/2", inc, sel); end
        u = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if ({cursor, blink_en, blink_on, inc, dec, sel, commit, timeout} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0})
            begin errors++; $display("FAIL async_reset cursor=%0d en=%0b bo=%0b inc=%0b sel=%0d", cursor, blink_en, blink_on, inc, sel); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({cursor, inc, commit, timeout} !== 6'd0) begin errors++; $display("FAIL post_reset got=%b exp=0", {cursor, inc, commit, timeout}); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_cursor();
        test_step();
        test_priority();
        test_blink_timeout();
        test_reset_mid_edit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/watch_edit_ctrl.md
# watch_edit_ctrl

Parametrised edit-mode controller for the watch display. It holds the cursor over `NUM_DIGITS` editable fields and turns up/down presses into per-field increment/decrement pulses for the time-keeping datapath. It also generates the blink phase for the selected field and reports how edit mode ended, by commit or by timeout. It sits between the button debounce/edge-detect stage and the watch counter/FND display blocks.

## Interface
- `NUM_DIGITS`, 4: number of editable fields, 2..15.
- `TIMEOUT_TICKS`, 10: `i_tick` pulses of inactivity before edit mode exits automatically.
- `BLINK_TICKS`, 1: `i_tick` pulses per blink half-period, ≥1.
- Derived: `CW = $clog2(NUM_DIGITS+1)`.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous reset, active-low.
- `i_btn_center`  in  1  enter/exit edit; one-cycle pulse.
- `i_btn_left`  in  1  cursor left; one-cycle pulse.
- `i_btn_right`  in  1  cursor right; one-cycle pulse.
- `i_btn_up`  in  1  increment selected field; one-cycle pulse.
- `i_btn_down`  in  1  decrement selected field; one-cycle pulse.
- `i_tick`  in  1  one-cycle time-base strobe.
- `o_cursor`  out  CW  0 = idle; 1..`NUM_DIGITS` = selected field, 1 = leftmost.
- `o_blink_en`  out  1  high when `o_cursor` ≠ 0.
- `o_blink_on`  out  1  display phase of the selected field (1 = visible).
- `o_inc`, `o_dec`  out  1  one-cycle step pulses.
- `o_sel`  out  CW  field index qualifying `o_inc`/`o_dec`.
- `o_commit`  out  1  one-cycle pulse when edit mode is exited by centre.
- `o_timeout`  out  1  one-cycle pulse when edit mode is exited by inactivity.

## Operation
- Inputs are already debounced single-cycle pulses.
- When several inputs are high in one cycle, only the highest-priority one acts: centre > right > left > up > down.
- **IDLE** (cursor 0):
  - centre → cursor 1.
  - All other buttons are ignored: no pulses, no state change.
- **EDIT** (cursor k, 1..N):
  - centre → cursor 0 and `o_commit`.
  - right → k+1, wrapping N→1.
  - left → k−1, wrapping 1→N.
  - up → `o_inc` with `o_sel`=k; cursor unchanged.
  - down → `o_dec` with `o_sel`=k; cursor unchanged.
- **Blink**:
  - In IDLE, `o_blink_on`=1 and the phase counter is held at 0.
  - In EDIT, the phase counter counts `i_tick`; at `BLINK_TICKS` it clears and `o_blink_on` toggles.
  - Any accepted button in EDIT, including the entering centre press, forces `o_blink_on`=1 and clears the phase counter.
- **Inactivity** (macro-enabled only):
  - In EDIT, the idle counter counts `i_tick`.
  - Any accepted button clears it.
  - When it reaches `TIMEOUT_TICKS`: cursor goes to 0 and `o_timeout` pulses. `o_commit` does not pulse.
- **Simultaneous events**:
  - A button and `i_tick` in the same cycle: the button wins. The idle and phase counters clear and the tick is discarded.
  - Centre in the same cycle as the timeout: centre wins, giving `o_commit` only.
- **Counter widths**:
  - Phase counter: `$clog2(BLINK_TICKS+1)` bits.
  - Idle counter: `$clog2(TIMEOUT_TICKS+1)` bits.
  - Neither counter exceeds its limit.

## Timing
- All outputs are registered. Response appears on the first rising edge after the input cycle: 1-cycle latency.
- `o_blink_en` is decoded from the cursor register and is valid in the same cycle as `o_cursor`.
- `o_inc`/`o_dec`/`o_commit`/`o_timeout` are high for exactly one cycle per event. `o_sel` is 0 whenever `o_inc`/`o_dec` are low.
- Reset values:
  - `o_cursor`=0, `o_blink_en`=0, `o_blink_on`=1.
  - `o_inc`=`o_dec`=`o_commit`=`o_timeout`=0, `o_sel`=0.
  - Both counters 0.
- Reset asserted mid-edit returns to IDLE immediately, with no commit or timeout pulse. Any in-flight pulse is cleared.

## Configuration
- `WATCH_EDIT_TIMEOUT_EN` defined:
  - The inactivity counter and `o_timeout` behave as above.
- Not defined:
  - The idle counter is not built and `o_timeout` is tied to 0.
  - EDIT is left only by centre or reset.
  - All other behaviour is identical.

## Test plan
All scenarios use `NUM_DIGITS`=4, `TIMEOUT_TICKS`=3, `BLINK_TICKS`=2.
- Reset release, then `up` in IDLE → cursor 0, `blink_on`=1, no `o_inc`.
- Centre, then right ×4, then left ×1 → cursor 1,2,3,4,1,4. Centre → cursor 0 with a one-cycle `o_commit`.
- Edit at cursor 3, then `up`, then `down` → `o_inc`+`o_sel`=3, then `o_dec`+`o_sel`=3, each exactly one cycle; cursor stays 3.
- In EDIT, left+right+up in one cycle → cursor k+1 only, no `o_inc`. Centre+right in one cycle → exit with `o_commit`.
- In EDIT, ticks with no buttons → `blink_on` toggles every 2 ticks. With the macro defined, the 3rd tick → cursor 0 and `o_timeout`. A button on the 2nd tick restarts the count, and a further 3 ticks are then required. With the macro undefined, cursor stays set after 10 ticks.
- Reset asserted at cursor 2 with `o_inc` pending → all outputs at reset values asynchronously; no pulse after release.
